// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared constants and FSM state encoding for the extended
//               UART receiver (parity modes, receiver states).
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    // Parity mode selector values for the PARITY parameter
    localparam int PARITY_NONE = 0;
    localparam int PARITY_ODD  = 1;
    localparam int PARITY_EVEN = 2;

    // Receiver FSM states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_START      = 3'd1,
        ST_DATA       = 3'd2,
        ST_PARITY     = 3'd3,
        ST_STOP       = 3'd4,
        ST_BREAK_WAIT = 3'd5
    } state_t;

endpackage
`default_nettype wire

// File: rtl/uart_sampler.sv
`default_nettype none
// ============================================================================
// Module      : uart_sampler
// Description : Serial-line synchroniser plus 3-sample majority voter.
//               Samples the synchronised line at cnt = HALF-1 and HALF; the
//               third sample is the live line at cnt = HALF+1, so 'vote' is
//               meaningful in the cycle where cnt = HALF+1.
// Ports       : clk, rst_n  - clock, async active-low reset
//               serial      - raw RX pin (asynchronous, idle high)
//               cnt         - bit-phase counter from the receiver FSM
//               s           - synchronised line
//               vote        - majority of the three samples of this bit
// Revision    : 1.0 - initial release
// ============================================================================
module uart_sampler #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 3,
    parameter int HALF        = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             serial,
    input  logic [CNT_W-1:0] cnt,
    output logic             s,
    output logic             vote
);

    localparam logic [CNT_W-1:0] c_SAMP0 = CNT_W'(HALF - 1);
    localparam logic [CNT_W-1:0] c_SAMP1 = CNT_W'(HALF);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_samp0;
    logic                   r_samp1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync  <= '1;
            r_samp0 <= 1'b1;
            r_samp1 <= 1'b1;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], serial};
            if (cnt == c_SAMP0) r_samp0 <= s;
            if (cnt == c_SAMP1) r_samp1 <= s;
        end
    end

    assign s    = r_sync[SYNC_STAGES-1];
    assign vote = (r_samp0 & r_samp1) | (r_samp0 & s) | (r_samp1 & s);

endmodule
`default_nettype wire

// File: rtl/uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_ext
// Description : Parametrised UART receiver with parity check, 1..2 stop
//               bits, majority-voted sampling, error reporting and a
//               valid/ready output handshake.
// Ports       : clk, rst_n         - clock, async active-low reset
//               serial             - RX line, idle high, async to clk
//               data               - received word, stable while valid
//               valid / ready      - output handshake
//               parity_err         - parity mismatch of the held word
//               frame_err          - a stop bit of the held word was 0
//               overrun            - 1-cycle pulse, completed frame dropped
//               busy               - receiver not idle
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_ext
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int CLK_PER_BIT = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 serial,
    output logic [DATA_BITS-1:0] data,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun,
    output logic                 busy
);

    localparam int c_HALF  = (CLK_PER_BIT - 1) / 2;
    localparam int c_CNT_W = $clog2(CLK_PER_BIT);
    localparam int c_IDX_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_DECIDE    = c_CNT_W'(c_HALF + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST  = c_CNT_W'(CLK_PER_BIT - 1);
    localparam logic [c_IDX_W-1:0] c_DATA_DONE = c_IDX_W'(DATA_BITS);
    localparam logic [c_IDX_W-1:0] c_STOP_LAST = c_IDX_W'(STOP_BITS - 1);
    localparam logic               c_ODD       = (PARITY == PARITY_ODD);

    state_t               r_state;
    logic [c_CNT_W-1:0]   r_cnt;
    logic [c_IDX_W-1:0]   r_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_perr;
    logic                 r_ferr;

    logic w_s;
    logic w_vote;
    logic w_decide;
    logic w_wrap;
    logic w_ferr_new;
    logic w_break;

    uart_sampler #(
        .SYNC_STAGES (SYNC_STAGES),
        .CNT_W       (c_CNT_W),
        .HALF        (c_HALF)
    ) u_sampler (
        .clk    (clk),
        .rst_n  (rst_n),
        .serial (serial),
        .cnt    (r_cnt),
        .s      (w_s),
        .vote   (w_vote)
    );

    assign w_decide   = (r_cnt == c_DECIDE);
    assign w_wrap     = (r_cnt == c_CNT_LAST);
    assign w_ferr_new = r_ferr | ~w_vote;
    // Low stop bit on an all-zero word: the line is in a break condition
    assign w_break    = ~w_vote & (r_shift == '0);
    assign busy       = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= ST_IDLE;
            r_cnt      <= '0;
            r_idx      <= '0;
            r_shift    <= '0;
            r_perr     <= 1'b0;
            r_ferr     <= 1'b0;
            data       <= '0;
            valid      <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            overrun <= 1'b0;

            // Consumer take; a completion in the same cycle re-asserts valid
            if (valid && ready) valid <= 1'b0;

            // Free-running bit-phase counter while a frame is in progress
            if (r_state != ST_IDLE && r_state != ST_BREAK_WAIT)
                r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;

            case (r_state)
                ST_IDLE: begin
                    if (!w_s) begin
                        r_state <= ST_START;
                        r_cnt   <= c_CNT_W'(1);
                        r_idx   <= '0;
                        r_perr  <= 1'b0;
                        r_ferr  <= 1'b0;
                    end
                end

                ST_START: begin
                    if (w_decide && w_vote) begin
                        r_state <= ST_IDLE;
                        r_cnt   <= '0;
                    end else if (w_wrap) begin
                        r_state <= ST_DATA;
                    end
                end

                ST_DATA: begin
                    if (w_decide) begin
                        // LSB first: after DATA_BITS shifts bit 0 is the first one
                        r_shift <= {w_vote, r_shift[DATA_BITS-1:1]};
                        r_idx   <= r_idx + 1'b1;
                    end
                    if (w_wrap && r_idx == c_DATA_DONE) begin
                        r_idx   <= '0;
                        r_state <= (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
                    end
                end

                ST_PARITY: begin
                    if (w_decide) r_perr <= (^r_shift) ^ w_vote ^ c_ODD;
                    if (w_wrap)   r_state <= ST_STOP;
                end

                ST_STOP: begin
                    if (w_decide) begin
                        r_ferr <= w_ferr_new;
                        if (r_idx == c_STOP_LAST) begin
                            // Frame completes mid stop bit so a following
                            // start edge is not missed
                            r_state <= w_break ? ST_BREAK_WAIT : ST_IDLE;
                            r_cnt   <= '0;
                            if (!valid || ready) begin
                                data       <= r_shift;
                                parity_err <= r_perr;
                                frame_err  <= w_ferr_new;
                                valid      <= 1'b1;
                            end else begin
                                overrun <= 1'b1;
                            end
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end

                ST_BREAK_WAIT: begin
                    if (w_s) r_state <= ST_IDLE;
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ext.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_ext
// Description : Self-checking bench for uart_rx_ext. Two instances: 8N1 and
//               8E1. Expected words are queued from the frames the bench
//               transmits and compared when the consumer accepts a word.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_ext;

    localparam int CPB  = 8;
    localparam int SYNC = 2;

    typedef struct {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ser_n = 1'b1, ser_e = 1'b1;
    logic       rdy_n = 1'b1, rdy_e = 1'b1;
    logic [7:0] data_n, data_e;
    logic       valid_n, valid_e, perr_n, perr_e, ferr_n, ferr_e;
    logic       ovr_n, ovr_e, busy_n, busy_e;

    int   n_checks = 0;
    int   n_errors = 0;
    int   cyc = 0;
    int   vcyc_n = 0, ov_cnt_n = 0, ov_cnt_e = 0, rise_n = 0;
    logic pv_n = 1'b0;
    bit   rnd_on = 1'b0;
    exp_t qn[$];
    exp_t qe[$];

    uart_rx_ext #(.DATA_BITS(8), .PARITY(0), .STOP_BITS(1),
                  .CLK_PER_BIT(CPB), .SYNC_STAGES(SYNC)) u_dut_n (
        .clk(clk), .rst_n(rst_n), .serial(ser_n), .data(data_n),
        .valid(valid_n), .ready(rdy_n), .parity_err(perr_n),
        .frame_err(ferr_n), .overrun(ovr_n), .busy(busy_n));

    uart_rx_ext #(.DATA_BITS(8), .PARITY(2), .STOP_BITS(1),
                  .CLK_PER_BIT(CPB), .SYNC_STAGES(SYNC)) u_dut_e (
        .clk(clk), .rst_n(rst_n), .serial(ser_e), .data(data_e),
        .valid(valid_e), .ready(rdy_e), .parity_err(perr_e),
        .frame_err(ferr_e), .overrun(ovr_e), .busy(busy_e));

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive one line level for n clock cycles; entered and left at posedge+1
    task automatic hold(input int which, input logic v, input int n);
        if (which == 0) ser_n = v;
        else            ser_e = v;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Transmit one frame; which=0 -> 8N1 line, which=1 -> 8E1 line
    task automatic send_frame(input int which, input logic [7:0] w, input logic pflip,
                              input int spike_bit, input logic push);
        logic pbit;
        exp_t e;
        pbit = (^w) ^ pflip;
        if (push) begin
            e.d  = w;
            e.pe = (which == 1) ? ((($countones(w) + int'(pbit)) % 2) != 0) : 1'b0;
            e.fe = 1'b0;
            if (which == 0) qn.push_back(e);
            else            qe.push_back(e);
        end
        hold(which, 1'b0, CPB);
        for (int i = 0; i < 8; i++) begin
            if (i == spike_bit) begin
                hold(which, w[i], 3);
                hold(which, ~w[i], 1);
                hold(which, w[i], CPB - 4);
            end else begin
                hold(which, w[i], CPB);
            end
        end
        if (which == 1) hold(which, pbit, CPB);
        hold(which, 1'b1, CPB);
    endtask

    // Consumer-side monitors: every accepted word is compared with the queue
    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (valid_n) vcyc_n++;
            if (valid_n && !pv_n) rise_n = cyc;
            if (ovr_n) ov_cnt_n++;
            if (valid_n && rdy_n) begin
                chk("n_word_expected", 32'(qn.size() > 0), 32'd1);
                if (qn.size() > 0) begin
                    e = qn.pop_front();
                    chk("n_data", 32'(data_n), 32'(e.d));
                    chk("n_parity_err", 32'(perr_n), 32'(e.pe));
                    chk("n_frame_err", 32'(ferr_n), 32'(e.fe));
                end
            end
        end
        pv_n = valid_n;
    end

    initial forever begin
        exp_t e;
        @(negedge clk);
        if (rst_n) begin
            if (ovr_e) ov_cnt_e++;
            if (valid_e && rdy_e) begin
                chk("e_word_expected", 32'(qe.size() > 0), 32'd1);
                if (qe.size() > 0) begin
                    e = qe.pop_front();
                    chk("e_data", 32'(data_e), 32'(e.d));
                    chk("e_parity_err", 32'(perr_e), 32'(e.pe));
                    chk("e_frame_err", 32'(ferr_e), 32'(e.fe));
                end
            end
        end
    end

    // Random consumer back-pressure during the random phase
    initial forever begin
        @(posedge clk);
        #1;
        if (rnd_on) begin
            rdy_n = ($urandom_range(0, 3) != 0);
            rdy_e = ($urandom_range(0, 3) != 0);
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "timeout");
    end

    initial begin
        int c0, v0, o0, lat_exp;
        bit saw_busy;

        // Reset values
        #23;
        chk("rst_data_n", 32'(data_n), 0);
        chk("rst_valid_n", 32'(valid_n), 0);
        chk("rst_busy_n", 32'(busy_n), 0);
        chk("rst_flags_n", 32'({perr_n, ferr_n, ovr_n}), 0);
        chk("rst_valid_e", 32'(valid_e), 0);
        chk("rst_busy_e", 32'(busy_e), 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        hold(0, 1'b1, 2 * CPB);

        // 8N1 0xA5: one valid cycle, fixed latency
        c0 = cyc;
        v0 = vcyc_n;
        send_frame(0, 8'hA5, 1'b0, -1, 1'b1);
        hold(0, 1'b1, 2 * CPB);
        lat_exp = (8 + 0 + 1) * CPB + (CPB - 1) / 2 + 1 + 1 + SYNC;
        chk("a5_valid_cycles", 32'(vcyc_n - v0), 1);
        chk("a5_latency", 32'(rise_n - c0), 32'(lat_exp));

        // 8E1 0x3C with wrong then correct parity bit
        send_frame(1, 8'h3C, 1'b1, -1, 1'b1);
        send_frame(1, 8'h3C, 1'b0, -1, 1'b1);
        hold(1, 1'b1, 2 * CPB);

        // 2-cycle glitch on idle line
        v0 = vcyc_n;
        saw_busy = 1'b0;
        hold(0, 1'b0, 2);
        ser_n = 1'b1;
        for (int i = 0; i < CPB; i++) begin
            @(negedge clk);
            if (busy_n) saw_busy = 1'b1;
        end
        repeat (SYNC + 2) @(posedge clk);
        #1;
        chk("glitch_busy_seen", 32'(saw_busy), 1);
        chk("glitch_busy_dropped", 32'(busy_n), 0);
        hold(0, 1'b1, 2 * CPB);
        chk("glitch_no_valid", 32'(vcyc_n - v0), 0);

        // 1-cycle spike inside data bits
        send_frame(0, 8'hC3, 1'b0, 3, 1'b1);
        send_frame(0, 8'h5A, 1'b0, 6, 1'b1);
        hold(0, 1'b1, 2 * CPB);

        // Break: line low for 20 bit times -> one zero word with frame error
        qn.push_back('{d: 8'h00, pe: 1'b0, fe: 1'b1});
        v0 = vcyc_n;
        hold(0, 1'b0, 20 * CPB);
        hold(0, 1'b1, 2 * CPB);
        chk("break_one_word", 32'(vcyc_n - v0), 1);
        send_frame(0, 8'h55, 1'b0, -1, 1'b1);
        hold(0, 1'b1, 2 * CPB);

        // Overrun: ready low, 0x11 then 0x22 back-to-back
        rdy_n = 1'b0;
        o0 = ov_cnt_n;
        send_frame(0, 8'h11, 1'b0, -1, 1'b1);
        send_frame(0, 8'h22, 1'b0, -1, 1'b0);
        hold(0, 1'b1, 2 * CPB);
        chk("ovr_valid_held", 32'(valid_n), 1);
        chk("ovr_data_kept", 32'(data_n), 32'h11);
        chk("ovr_pulse_once", 32'(ov_cnt_n - o0), 1);
        rdy_n = 1'b1;
        hold(0, 1'b1, CPB);
        rdy_n = 1'b0;

        // Same, but ready high exactly on the completion cycle of 0x22
        o0 = ov_cnt_n;
        fork
            begin
                send_frame(0, 8'h11, 1'b0, -1, 1'b1);
                send_frame(0, 8'h22, 1'b0, -1, 1'b1);
            end
            begin
                repeat (10 * CPB + lat_exp - 1) @(posedge clk);
                #1;
                rdy_n = 1'b1;
                @(posedge clk);
                #1;
                rdy_n = 1'b0;
            end
        join
        hold(0, 1'b1, 2 * CPB);
        chk("repl_valid", 32'(valid_n), 1);
        chk("repl_data", 32'(data_n), 32'h22);
        chk("repl_no_overrun", 32'(ov_cnt_n - o0), 0);
        rdy_n = 1'b1;
        hold(0, 1'b1, CPB);

        // Random frames on both lines with random back-pressure
        rnd_on = 1'b1;
        fork
            begin
                for (int k = 0; k < 12; k++) begin
                    int sp, gap;
                    sp  = $urandom_range(0, 8);
                    gap = $urandom_range(0, 2);
                    send_frame(0, 8'($urandom), 1'b0, (sp == 8) ? -1 : sp, 1'b1);
                    if (gap > 0) hold(0, 1'b1, gap * CPB);
                end
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    int gap;
                    gap = $urandom_range(0, 2);
                    send_frame(1, 8'($urandom), 1'($urandom_range(0, 1)), -1, 1'b1);
                    if (gap > 0) hold(1, 1'b1, gap * CPB);
                end
            end
        join
        rnd_on = 1'b0;
        hold(0, 1'b1, 3 * CPB);
        rdy_n = 1'b1;
        rdy_e = 1'b1;
        hold(0, 1'b1, CPB);

        // Reset in the middle of the data bits of 0x7E
        fork
            send_frame(0, 8'h7E, 1'b0, -1, 1'b0);
            begin
                repeat (5 * CPB) @(posedge clk);
                #2;
                rst_n = 1'b0;
                #1;
                chk("midrst_busy", 32'(busy_n), 0);
                chk("midrst_valid", 32'(valid_n), 0);
                chk("midrst_data", 32'(data_n), 0);
            end
        join
        hold(0, 1'b1, 2 * CPB);
        rst_n = 1'b1;
        hold(0, 1'b1, CPB);
        send_frame(0, 8'h81, 1'b0, -1, 1'b1);
        hold(0, 1'b1, 2 * CPB);

        chk("n_queue_drained", 32'(qn.size()), 0);
        chk("e_queue_drained", 32'(qe.size()), 0);
        chk("n_total_overruns", 32'(ov_cnt_n), 1);
        chk("e_total_overruns", 32'(ov_cnt_e), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
